// File: rtl/cla_pipe_adder_pkg.sv
// Shared configuration for the pipelined carry-lookahead adder.
// Holds the default geometry, the slice-width helper and the geometry check
// used at elaboration time by cla_pipe_adder.
package cla_pipe_adder_pkg;

  localparam int unsigned DEF_WIDTH  = 32;
  localparam int unsigned DEF_GROUP  = 4;
  localparam int unsigned DEF_STAGES = 2;

  // Bits resolved per pipeline stage.
  function automatic int unsigned slice_width(input int unsigned width,
                                              input int unsigned stages);
    return width / stages;
  endfunction

  // Geometry is legal only when every stage holds a whole number of groups.
  function automatic bit cfg_ok(input int unsigned width,
                                input int unsigned group,
                                input int unsigned stages);
    return (group != 0) && (stages != 0) && ((width % (group * stages)) == 0);
  endfunction

endpackage

// File: rtl/cla_pipe_adder_group.sv
// cla_group: combinational GROUP-bit carry-lookahead block.
// Ports:
//   a, b  : operand bits (b is already the effective, possibly inverted, operand)
//   ci    : carry into the group
//   sum   : group sum bits
//   p, g  : group propagate / generate (g is the carry-out with ci forced 0)
//   co    : carry out of the group
module cla_group
  import cla_pipe_adder_pkg::*;
#(
  parameter int unsigned GROUP = DEF_GROUP
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             ci,
  output logic [GROUP-1:0] sum,
  output logic             p,
  output logic             g,
  output logic             co
);

  logic [GROUP-1:0] bp;
  logic [GROUP-1:0] bg;
  logic [GROUP:0]   c;
  logic             acc;
  logic             pp;

  assign bp = a ^ b;
  assign bg = a & b;

  // Every carry is a flat sum of products over the bit p/g terms (no ripple).
  always_comb begin
    c   = '0;
    g   = 1'b0;
    acc = 1'b0;
    pp  = 1'b1;
    for (int i = 0; i <= int'(GROUP); i++) begin
      acc = 1'b0;
      pp  = 1'b1;
      for (int j = i - 1; j >= 0; j--) begin
        acc = acc | (bg[j] & pp);
        pp  = pp & bp[j];
      end
      c[i] = acc | (pp & ci);
      if (i == int'(GROUP)) g = acc;
    end
  end

  assign sum = bp ^ c[GROUP-1:0];
  assign p   = &bp;
  assign co  = c[GROUP];

endmodule

// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: pipelined carry-lookahead adder/subtractor with a
// valid/ready handshake. Slice k of the word is resolved in stage k; the
// carry and the accumulated word P/G are registered between stages.
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   in_valid / in_ready   : operand handshake (in_ready is 0 during reset)
//   A, B, Cin, Sub        : operands, carry-in (add only), subtract select
//   out_valid / out_ready : result handshake
//   Sum, Cout, Ovf        : result, carry out of MSB, signed overflow
//   Zero                  : result valid and Sum == 0
//   P, G                  : word propagate / generate
module cla_pipe_adder
  import cla_pipe_adder_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned GROUP  = DEF_GROUP,
  parameter int unsigned STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf,
  output logic             Zero,
  output logic             P,
  output logic             G
);

  localparam int unsigned S  = slice_width(WIDTH, STAGES);
  localparam int unsigned NG = S / GROUP;

  if (!cfg_ok(WIDTH, GROUP, STAGES)) begin : g_cfg_check
    $error("cla_pipe_adder: WIDTH must be a multiple of GROUP*STAGES");
  end

  // Pipeline registers, one element per stage.
  logic [STAGES-1:0] v_r;
  logic [STAGES-1:0] c_r;
  logic [STAGES-1:0] p_r;
  logic [STAGES-1:0] g_r;
  logic [WIDTH-1:0]  sum_r [STAGES];
  logic [WIDTH-1:0]  a_r   [STAGES];
  logic [WIDTH-1:0]  b_r   [STAGES];
  logic              ovf_r;

  // Next-state values produced by each stage's slice logic.
  logic [STAGES-1:0] rdy;
  logic [STAGES-1:0] up_v;
  logic [STAGES-1:0] c_nx;
  logic [STAGES-1:0] p_nx;
  logic [STAGES-1:0] g_nx;
  logic [WIDTH-1:0]  sum_nx [STAGES];
  logic [WIDTH-1:0]  a_nx   [STAGES];
  logic [WIDTH-1:0]  b_nx   [STAGES];
  logic              ovf_nx;
  logic              rdy_acc;

  logic [WIDTH-1:0]  b_eff;
  logic              c0;

  // Subtract is A + ~B + 1, so Cin is overridden in that mode.
  assign b_eff = Sub ? ~B : B;
  assign c0    = Sub | Cin;

  // ready_k = !valid_k || ready_{k+1}, unrolled from the output end.
  always_comb begin
    rdy     = '0;
    rdy_acc = out_ready;
    for (int k = int'(STAGES) - 1; k >= 0; k--) begin
      rdy_acc = rdy_acc | ~v_r[k];
      rdy[k]  = rdy_acc;
    end
  end

  always_comb begin
    up_v    = '0;
    up_v[0] = in_valid;
    for (int k = 1; k < int'(STAGES); k++) up_v[k] = v_r[k-1];
  end

  assign in_ready = rdy[0] & rst_n;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned LO = k * S;

    logic [S-1:0]     sa;
    logic [S-1:0]     sb;
    logic [S-1:0]     ssum;
    logic             sci;
    logic             pin;
    logic             gin;
    logic [WIDTH-1:0] sum_in;
    logic [WIDTH-1:0] snx;
    logic [NG-1:0]    gp;
    logic [NG-1:0]    gg;
    logic [NG-1:0]    gco;
    logic [NG-1:0]    cg;
    logic [NG:0]      la_g;
    logic [NG:0]      la_pp;
    logic             la_acc;
    logic             la_p;
    logic             unused_co;

    if (k == 0) begin : g_first
      assign sa      = A[S-1:0];
      assign sb      = b_eff[S-1:0];
      assign sci     = c0;
      assign pin     = 1'b1;
      assign gin     = 1'b0;
      assign sum_in  = '0;
      assign a_nx[k] = A;
      assign b_nx[k] = b_eff;
    end else begin : g_next
      assign sa      = a_r[k-1][LO +: S];
      assign sb      = b_r[k-1][LO +: S];
      assign sci     = c_r[k-1];
      assign pin     = p_r[k-1];
      assign gin     = g_r[k-1];
      assign sum_in  = sum_r[k-1];
      assign a_nx[k] = a_r[k-1];
      assign b_nx[k] = b_r[k-1];
    end

    // Group-level lookahead: la_g[i]/la_pp[i] are generate/propagate of groups 0..i-1.
    always_comb begin
      la_g   = '0;
      la_pp  = '0;
      la_acc = 1'b0;
      la_p   = 1'b1;
      for (int i = 0; i <= int'(NG); i++) begin
        la_acc = 1'b0;
        la_p   = 1'b1;
        for (int j = i - 1; j >= 0; j--) begin
          la_acc = la_acc | (gg[j] & la_p);
          la_p   = la_p & gp[j];
        end
        la_g[i]  = la_acc;
        la_pp[i] = la_p;
      end
    end

    for (genvar m = 0; m < NG; m++) begin : g_grp
      assign cg[m] = la_g[m] | (la_pp[m] & sci);

      cla_group #(.GROUP(GROUP)) u_grp (
        .a   (sa[m*GROUP +: GROUP]),
        .b   (sb[m*GROUP +: GROUP]),
        .ci  (cg[m]),
        .sum (ssum[m*GROUP +: GROUP]),
        .p   (gp[m]),
        .g   (gg[m]),
        .co  (gco[m])
      );
    end

    // Only the top group's carry leaves the slice; the rest duplicate cg.
    assign unused_co = &gco;

    always_comb begin
      snx           = sum_in;
      snx[LO +: S]  = ssum;
    end

    assign sum_nx[k] = snx;
    assign c_nx[k]   = gco[NG-1];
    assign p_nx[k]   = pin & la_pp[NG];
    assign g_nx[k]   = la_g[NG] | (la_pp[NG] & gin);

    // Carry into the MSB is recovered from the MSB sum bit.
    if (k == STAGES - 1) begin : g_last
      assign ovf_nx = ssum[S-1] ^ sa[S-1] ^ sb[S-1] ^ gco[NG-1];
    end
  end

  // A stage loads only on a transfer into it and otherwise holds.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_r   <= '0;
      c_r   <= '0;
      p_r   <= '0;
      g_r   <= '0;
      ovf_r <= 1'b0;
      for (int k = 0; k < int'(STAGES); k++) begin
        sum_r[k] <= '0;
        a_r[k]   <= '0;
        b_r[k]   <= '0;
      end
    end else begin
      for (int k = 0; k < int'(STAGES); k++) begin
        if (rdy[k]) v_r[k] <= up_v[k];
        if (rdy[k] && up_v[k]) begin
          sum_r[k] <= sum_nx[k];
          a_r[k]   <= a_nx[k];
          b_r[k]   <= b_nx[k];
          c_r[k]   <= c_nx[k];
          p_r[k]   <= p_nx[k];
          g_r[k]   <= g_nx[k];
        end
      end
      if (rdy[STAGES-1] && up_v[STAGES-1]) ovf_r <= ovf_nx;
    end
  end

  logic unused_ops;
  assign unused_ops = ^{a_r[STAGES-1], b_r[STAGES-1]};

  assign out_valid = v_r[STAGES-1];
  assign Sum       = sum_r[STAGES-1];
  assign Cout      = c_r[STAGES-1];
  assign Ovf       = ovf_r;
  assign P         = p_r[STAGES-1];
  assign G         = g_r[STAGES-1];
  assign Zero      = v_r[STAGES-1] & (sum_r[STAGES-1] == '0);

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Bench for cla_pipe_adder: table vectors, random traffic with backpressure
// and hand-written reset / stall sequences, checked through a scoreboard.
module tb_cla_pipe_adder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A;
  logic [31:0] B;
  logic        Cin;
  logic        Sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Sum;
  logic        Cout;
  logic        Ovf;
  logic        Zero;
  logic        P;
  logic        G;

  cla_pipe_adder #(.WIDTH(32), .GROUP(4), .STAGES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
    .Sub       (Sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Sum       (Sum),
    .Cout      (Cout),
    .Ovf       (Ovf),
    .Zero      (Zero),
    .P         (P),
    .G         (G)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] sum;
    logic        cout, ovf, zero, p, g;
    int          acc_cyc;
    bit          chk_lat;
  } exp_t;

  typedef struct {
    logic [31:0] a, b;
    logic        cin, sub;
    logic [31:0] sum;
    logic        cout, ovf, zero, p, g;
  } vec_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   n_acc = 0;
  int   last_acc = 0;
  bit   lat_chk = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain 33-bit arithmetic on the effective operands.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic cin, input logic sub);
    exp_t        e;
    logic [31:0] bp;
    logic        c;
    logic [32:0] full;
    logic [32:0] nocin;
    bp    = sub ? ~b : b;
    c     = sub ? 1'b1 : cin;
    full  = {1'b0, a} + {1'b0, bp} + 33'(c);
    nocin = {1'b0, a} + {1'b0, bp};
    e.sum  = full[31:0];
    e.cout = full[32];
    e.ovf  = (a[31] == bp[31]) && (full[31] != a[31]);
    e.zero = (full[31:0] == 32'h0);
    e.p    = &(a ^ bp);
    e.g    = nocin[32];
    e.acc_cyc = 0;
    e.chk_lat = 1'b0;
    return e;
  endfunction

  // Drive one transaction, hold it until accepted, push its expectation.
  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic cin, input logic sub, input exp_t e);
    int t;
    bit got;
    t = 0;
    got = 0;
    A = a; B = b; Cin = cin; Sub = sub; in_valid = 1'b1;
    while (!got) begin
      @(negedge clk);
      if (in_ready) begin
        e.acc_cyc = cyc;
        e.chk_lat = lat_chk;
        sbq.push_back(e);
        n_acc++;
        last_acc = cyc;
        got = 1;
      end else begin
        t++;
        if (t > 200) begin
          chk("send_timeout", 64'd1, 64'd0);
          got = 1;
        end
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sbq.size() != 0 && t < 100) begin
      @(posedge clk);
      t++;
    end
    chk("drain_left", 64'(sbq.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops on each output transfer and checks hold-while-stalled.
  initial begin
    exp_t        e;
    logic [36:0] held;
    bit          stalled;
    stalled = 0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stalled = 0;
      end else begin
        if (stalled) begin
          chk("stall_valid", 64'(out_valid), 64'd1);
          chk("stall_hold", 64'({Sum, Cout, Ovf, Zero, P, G}), 64'(held));
        end
        if (out_valid && !out_ready) begin
          stalled = 1;
          held = {Sum, Cout, Ovf, Zero, P, G};
        end else begin
          stalled = 0;
        end
        if (out_valid && out_ready) begin
          if (sbq.size() == 0) begin
            chk("unexpected_output", 64'd1, 64'd0);
          end else begin
            e = sbq.pop_front();
            chk("result", 64'({Sum, Cout, Ovf, Zero, P, G}),
                64'({e.sum, e.cout, e.ovf, e.zero, e.p, e.g}));
            if (e.chk_lat) chk("latency", 64'(cyc - e.acc_cyc), 64'd2);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[10];
    exp_t e;
    int   first_acc;
    int   acc0;
    bit   done;

    tbl[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[1] = '{32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{32'h7FFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{32'h12345678, 32'h12345678, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[6] = '{32'h00000000, 32'h00000000, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[7] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[8] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[9] = '{32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    // Reset held with live-looking input traffic.
    rst_n = 1'b0; in_valid = 1'b1; A = '1; B = '1; Cin = 1'b0; Sub = 1'b0; out_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_sum", 64'(Sum), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_flags", 64'({Cout, Ovf, Zero, P, G}), 64'd0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("rel_in_ready", 64'(in_ready), 64'd1);
    chk("rel_out_valid", 64'(out_valid), 64'd0);
    repeat (4) @(posedge clk);
    #1;

    // Table vectors back to back, no stalls: latency 2, one accept per cycle.
    lat_chk = 1;
    first_acc = 0;
    for (int i = 0; i < 10; i++) begin
      e.sum = tbl[i].sum; e.cout = tbl[i].cout; e.ovf = tbl[i].ovf;
      e.zero = tbl[i].zero; e.p = tbl[i].p; e.g = tbl[i].g;
      e.acc_cyc = 0; e.chk_lat = 1'b0;
      send(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, e);
      if (i == 0) first_acc = last_acc;
    end
    chk("throughput", 64'(last_acc - first_acc), 64'd9);
    drain();

    // Backpressure: 4 queued adds while the consumer stalls for 4 cycles.
    lat_chk = 0;
    out_ready = 1'b0;
    acc0 = n_acc;
    fork
      begin
        for (int i = 1; i <= 4; i++) send(32'(i), 32'(i), 1'b0, 1'b0, model(32'(i), 32'(i), 1'b0, 1'b0));
      end
      begin
        repeat (4) @(negedge clk);
        chk("bp_accepts", 64'(n_acc - acc0), 64'd2);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk("bp_out_valid", 64'(out_valid), 64'd1);
        chk("bp_sum", 64'(Sum), 64'd2);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Random traffic with a randomly stalling consumer.
    done = 0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          logic [31:0] ra, rb;
          logic        rc, rs;
          ra = $urandom; rb = $urandom;
          rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
          send(ra, rb, rc, rs, model(ra, rb, rc, rs));
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Mid-flight reset: two results in flight must never appear.
    out_ready = 1'b0;
    send(32'h00000010, 32'h00000020, 1'b0, 1'b0, model(32'h10, 32'h20, 1'b0, 1'b0));
    send(32'h00000030, 32'h00000040, 1'b0, 1'b0, model(32'h30, 32'h40, 1'b0, 1'b0));
    rst_n = 1'b0;
    sbq.delete();
    @(negedge clk);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_sum", 64'(Sum), 64'd0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    lat_chk = 1;
    send(32'h00001234, 32'h00004321, 1'b1, 1'b0, model(32'h1234, 32'h4321, 1'b1, 1'b0));
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cla_pipe_adder.md
Name: cla_pipe_adder

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor built from GROUP-bit lookahead groups.
- The word is split into STAGES equal slices. Slice k is resolved in pipeline stage k, and the registered carry ripples between stages.
- Uses a valid/ready handshake with full throughput and backpressure.
- Serves as the ALU/address adder for wide datapaths, replacing fixed 4-bit lookahead use.

Parameters:
- WIDTH, 32, operand width; must be a multiple of GROUP*STAGES.
- GROUP, 4, bits per lookahead group.
- STAGES, 2, pipeline depth and number of slices; slice width S = WIDTH/STAGES.

Ports:
- clk  input  1  clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operands valid
- in_ready  output  1  stage 0 can accept
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- Cin  input  1  carry-in (add mode only)
- Sub  input  1  1 = A - B
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts
- Sum  output  WIDTH  result
- Cout  output  1  carry out of MSB
- Ovf  output  1  signed overflow
- Zero  output  1  Sum == 0
- P  output  1  word propagate, AND of all (A^B') bits
- G  output  1  word generate, carry-out with carry-in forced 0

Behaviour:
- Interface: one clock, clk; reset rst_n is synchronous and active-low.
- Reset (rst_n=0 at a clk edge):
  - All stage valid bits clear, so out_valid=0.
  - Sum=0; Cout, Ovf, Zero, P and G are 0.
  - in_ready=0 while rst_n=0.
  - In-flight data is discarded, with no partial output.
- Effective operands:
  - B' = Sub ? ~B : B.
  - c0 = Sub ? 1 : Cin. Cin is ignored when Sub=1.
- Per bit: p = A^B', g = A&B'.
- Groups:
  - Group P/G computed by lookahead, not ripple.
  - Carries inside a slice come from group P/G lookahead.
- Stage k (0..STAGES-1):
  - Adds slice [k*S +: S] using the carry registered by stage k-1 (c0 for stage 0).
  - Registers: valid, partial Sum bits [0 .. (k+1)*S-1], carry-out, accumulated word P and G, and the unconsumed upper operand bits.
  - Operands above the slice are carried forward unchanged (skew registers).
- Accumulation: P_acc &= P_slice; G_acc = G_slice | (P_slice & G_acc).
- Outputs come from the last stage:
  - Cout = last carry.
  - Ovf = carry into MSB XOR Cout.
  - Zero = (Sum == 0), computed combinationally from the last-stage register.
- Handshake:
  - A transfer occurs when valid && ready.
  - ready_k = !valid_k || ready_{k+1}; ready_STAGES = out_ready; in_ready = ready_0 (when rst_n=1).
  - Bubbles collapse: an empty stage accepts even if downstream is stalled.
  - A stalled stage holds all of its registers stable.
  - The outputs must not change while out_valid=1 && out_ready=0.
- Latency and throughput:
  - Latency is exactly STAGES cycles from accept to out_valid when there are no stalls.
  - Throughput is 1 result per cycle.
  - Up to STAGES transactions can be in flight.
  - Ordering is strictly FIFO.
- Simultaneous accept and emit in one cycle is legal at every stage.
- Results are modulo 2^WIDTH; there is no saturation.

Decomposition:
- Shared package/header:
  - default WIDTH/GROUP/STAGES constants;
  - a derived slice-width function;
  - an elaboration check that WIDTH % (GROUP*STAGES) == 0.
- Sub-module cla_group: combinational GROUP-bit lookahead with inputs A, B', carry-in and outputs Sum, P, G, carry-out.
  - Instantiated WIDTH/GROUP times.
  - Group-to-group lookahead sits in the stage logic.
- Pipeline registers live in cla_pipe_adder.

Test Plan:
- Reset: rst_n=0 for 2 cycles with in_valid=1, A=B=all ones -> out_valid=0, Sum=0, in_ready=0; after release in_ready=1, nothing emitted.
- Add wrap: A=32'hFFFFFFFF, B=1, Cin=0, Sub=0, out_ready=1 -> 2 cycles later Sum=0, Cout=1, Zero=1, Ovf=0, P=0, G=1.
- Stage-boundary carry: A=32'h0000FFFF, B=1, Cin=0 -> Sum=32'h00010000, Cout=0. Also A=32'h7FFFFFFF, B=0, Cin=1 -> Sum=32'h80000000, Ovf=1, Cout=0.
- Subtract: A=5, B=7, Sub=1, Cin=1 (ignored) -> Sum=32'hFFFFFFFE, Cout=0, Ovf=0. Then A=32'h80000000, B=1, Sub=1 -> Sum=32'h7FFFFFFF, Cout=1, Ovf=1.
- Backpressure: 4 back-to-back transactions (1+1, 2+2, 3+3, 4+4) with out_ready=0 for 4 cycles -> in_ready falls after 2 accepts; out_valid holds Sum=2 stable; on release, outputs 2, 4, 6, 8 in order with no loss or duplicate.
- Mid-flight reset: 2 transactions in flight, rst_n=0 one cycle -> out_valid=0 next cycle; neither result ever appears; a new transaction after release completes with latency 2.
